// File: rtl/led_round_scheduler.sv
// Round scheduler for the two 3-bit code slots of the 4-LED pattern decoder.
// Collects codes from requesters A and B, shows the pair for a hold time, then blanks.
module led_round_scheduler #(
  parameter int         HOLD_CYCLES    = 25000000,
  parameter int         GAP_CYCLES     = 5000000,
  parameter int         TIMEOUT_CYCLES = 250000000,
  parameter int         CNT_W          = 28,
  parameter logic [2:0] BLANK_CODE     = 3'b011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic [2:0] a_code,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [2:0] b_code,
  output logic       b_ack,
  output logic [2:0] abc,
  output logic [2:0] def,
  output logic       show,
  output logic       busy,
  output logic       timeout_flag,
  output logic [7:0] round_cnt
);

  typedef enum logic [1:0] {COLLECT, SHOW, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_reg;
  logic             a_full_reg;
  logic             b_full_reg;
  logic [2:0]       a_reg;
  logic [2:0]       b_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic cap_a;
  logic cap_b;
  logic both_empty;
  logic both_full;

  assign both_empty = !a_full_reg && !b_full_reg;
  assign both_full  = a_full_reg && b_full_reg;
  assign cap_a      = (state_reg == COLLECT) && a_req && !a_full_reg;
  assign cap_b      = (state_reg == COLLECT) && b_req && !b_full_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= COLLECT;
      a_full_reg   <= 1'b0;
      b_full_reg   <= 1'b0;
      a_reg        <= BLANK_CODE;
      b_reg        <= BLANK_CODE;
      cnt_reg      <= '0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      abc          <= BLANK_CODE;
      def          <= BLANK_CODE;
      show         <= 1'b0;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
      round_cnt    <= 8'd0;
    end else begin
      a_ack <= cap_a;
      b_ack <= cap_b;
      case (state_reg)
        COLLECT: begin
          if (both_full) begin
            // Both slots load together so the decoder never sees a half-updated pair.
            abc       <= a_reg;
            def       <= b_reg;
            show      <= 1'b1;
            busy      <= 1'b1;
            cnt_reg   <= HOLD_LOAD;
            state_reg <= SHOW;
          end else begin
            if (cap_a) begin
              a_reg      <= a_code;
              a_full_reg <= 1'b1;
            end
            if (cap_b) begin
              b_reg      <= b_code;
              b_full_reg <= 1'b1;
            end
            if (both_empty) begin
              if (cap_a || cap_b) begin
                timeout_flag <= 1'b0;
                cnt_reg      <= TIMEOUT_LOAD;
              end
            end else if (!cap_a && !cap_b) begin
              // Exactly one slot is full here; a capture on the expiry edge takes priority.
              if (cnt_reg == '0) begin
                timeout_flag <= 1'b1;
                if (!a_full_reg) begin
                  a_reg      <= BLANK_CODE;
                  a_full_reg <= 1'b1;
                end else begin
                  b_reg      <= BLANK_CODE;
                  b_full_reg <= 1'b1;
                end
              end else begin
                cnt_reg <= cnt_reg - CNT_W'(1);
              end
            end
          end
        end
        SHOW: begin
          if (cnt_reg == '0) begin
            show      <= 1'b0;
            abc       <= BLANK_CODE;
            def       <= BLANK_CODE;
            round_cnt <= round_cnt + 8'd1;
            cnt_reg   <= GAP_LOAD;
            state_reg <= GAP;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_reg == '0) begin
            busy       <= 1'b0;
            a_full_reg <= 1'b0;
            b_full_reg <= 1'b0;
            state_reg  <= COLLECT;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_led_round_scheduler.sv
// Bench for led_round_scheduler: vector table, directed corner sequences and
// randomized requesters checked against a timestamp-based round model.
module tb_led_round_scheduler;

  localparam int HOLD  = 4;
  localparam int GAP   = 2;
  localparam int TOUT  = 10;
  localparam int BLANK = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [2:0] a_code = 3'd0, b_code = 3'd0;
  logic       a_ack, b_ack, show, busy, timeout_flag;
  logic [2:0] abc, def;
  logic [7:0] round_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_round_scheduler #(
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TOUT),
    .CNT_W(8), .BLANK_CODE(3'b011)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_code(a_code), .a_ack(a_ack),
    .b_req(b_req), .b_code(b_code), .b_ack(b_ack),
    .abc(abc), .def(def), .show(show), .busy(busy),
    .timeout_flag(timeout_flag), .round_cnt(round_cnt)
  );

  // Reference model: a round is described by capture and show-start timestamps.
  int   m_t, m_a, m_b, m_first, m_load, m_sa, m_sb, m_rc;
  logic m_tf, m_aack, m_back;

  task automatic model_reset();
    m_t = 0; m_a = -1; m_b = -1; m_first = 0; m_load = -1;
    m_sa = BLANK; m_sb = BLANK; m_rc = 0; m_tf = 1'b0; m_aack = 1'b0; m_back = 1'b0;
  endtask

  task automatic model_edge(input logic ar, input logic [2:0] ac, input logic br, input logic [2:0] bc);
    bit ca, cb, was_empty;
    int el;
    m_t++;
    m_aack = 1'b0;
    m_back = 1'b0;
    if (m_load >= 0) begin
      el = m_t - m_load;
      if (el == HOLD) m_rc = (m_rc + 1) % 256;
      if (el == HOLD + GAP) begin
        m_load = -1; m_a = -1; m_b = -1;
      end
    end else if (m_a >= 0 && m_b >= 0) begin
      m_load = m_t; m_sa = m_a; m_sb = m_b;
    end else begin
      was_empty = (m_a < 0) && (m_b < 0);
      ca = ar && (m_a < 0);
      cb = br && (m_b < 0);
      if (ca) begin m_a = int'(ac); m_aack = 1'b1; end
      if (cb) begin m_b = int'(bc); m_back = 1'b1; end
      if (was_empty) begin
        if (ca || cb) begin m_tf = 1'b0; m_first = m_t; end
      end else if (!ca && !cb && (m_t - m_first == TOUT)) begin
        if (m_a < 0) m_a = BLANK; else m_b = BLANK;
        m_tf = 1'b1;
      end
    end
  endtask

  function automatic bit m_show();
    return (m_load >= 0) && (m_t - m_load < HOLD);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".a_ack"}, 32'(a_ack), 32'(m_aack));
    chk({tag, ".b_ack"}, 32'(b_ack), 32'(m_back));
    chk({tag, ".show"}, 32'(show), 32'(m_show()));
    chk({tag, ".busy"}, 32'(busy), 32'(m_load >= 0));
    chk({tag, ".tflag"}, 32'(timeout_flag), 32'(m_tf));
    chk({tag, ".abc"}, 32'(abc), m_show() ? m_sa : BLANK);
    chk({tag, ".def"}, 32'(def), m_show() ? m_sb : BLANK);
    chk({tag, ".round_cnt"}, 32'(round_cnt), m_rc);
  endtask

  task automatic step(input logic ar, input logic [2:0] ac, input logic br, input logic [2:0] bc,
                      input bit cmp, input string tag);
    a_req = ar; a_code = ac; b_req = br; b_code = bc;
    @(posedge clk);
    model_edge(ar, ac, br, bc);
    #1;
    if (cmp) compare_model(tag);
    $display("%s t=%0t req=%b%b ack=%b%b show=%b busy=%b tf=%b abc=%b def=%b rc=%0d",
             tag, $time, ar, br, a_ack, b_ack, show, busy, timeout_flag, abc, def, round_cnt);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, tag);
  endtask

  typedef struct {
    logic       ar; logic [2:0] ac; logic br; logic [2:0] bc;
    logic       e_aack, e_back, e_show, e_busy, e_tf;
    logic [2:0] e_abc, e_def;
    logic [7:0] e_rc;
  } vec_t;

  function automatic vec_t mk(logic ar, logic [2:0] ac, logic br, logic [2:0] bc,
                              logic aa, logic ba, logic sh, logic bs, logic tf,
                              logic [2:0] ea, logic [2:0] ed, logic [7:0] rc);
    vec_t v;
    v.ar = ar; v.ac = ac; v.br = br; v.bc = bc;
    v.e_aack = aa; v.e_back = ba; v.e_show = sh; v.e_busy = bs; v.e_tf = tf;
    v.e_abc = ea; v.e_def = ed; v.e_rc = rc;
    return v;
  endfunction

  vec_t vt[11];

  initial begin
    int   n;
    logic a_pend, b_pend;
    logic [2:0] a_c, b_c;

    // A at row 0, B three cycles later; show 4 cycles, blank 2, then idle.
    vt[0]  = mk(1, 3'b010, 0, 3'b000, 1, 0, 0, 0, 0, 3'b011, 3'b011, 8'd0);
    vt[1]  = mk(0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0, 3'b011, 3'b011, 8'd0);
    vt[2]  = mk(0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0, 3'b011, 3'b011, 8'd0);
    vt[3]  = mk(0, 3'b000, 1, 3'b111, 0, 1, 0, 0, 0, 3'b011, 3'b011, 8'd0);
    vt[4]  = mk(0, 3'b000, 0, 3'b000, 0, 0, 1, 1, 0, 3'b010, 3'b111, 8'd0);
    vt[5]  = mk(0, 3'b000, 0, 3'b000, 0, 0, 1, 1, 0, 3'b010, 3'b111, 8'd0);
    vt[6]  = mk(0, 3'b000, 0, 3'b000, 0, 0, 1, 1, 0, 3'b010, 3'b111, 8'd0);
    vt[7]  = mk(0, 3'b000, 0, 3'b000, 0, 0, 1, 1, 0, 3'b010, 3'b111, 8'd0);
    vt[8]  = mk(0, 3'b000, 0, 3'b000, 0, 0, 0, 1, 0, 3'b011, 3'b011, 8'd1);
    vt[9]  = mk(0, 3'b000, 0, 3'b000, 0, 0, 0, 1, 0, 3'b011, 3'b011, 8'd1);
    vt[10] = mk(0, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0, 3'b011, 3'b011, 8'd1);

    // Reset held with random inputs toggling.
    model_reset();
    for (int i = 0; i < 3; i++) begin
      a_req = 1'($urandom); b_req = 1'($urandom);
      a_code = 3'($urandom); b_code = 3'($urandom);
      @(posedge clk); #1;
      compare_model("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(vt[i].ar, vt[i].ac, vt[i].br, vt[i].bc, 1'b0, "vec");
      chk($sformatf("vec%0d.a_ack", i), 32'(a_ack), 32'(vt[i].e_aack));
      chk($sformatf("vec%0d.b_ack", i), 32'(b_ack), 32'(vt[i].e_back));
      chk($sformatf("vec%0d.show", i), 32'(show), 32'(vt[i].e_show));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vt[i].e_busy));
      chk($sformatf("vec%0d.tflag", i), 32'(timeout_flag), 32'(vt[i].e_tf));
      chk($sformatf("vec%0d.abc", i), 32'(abc), 32'(vt[i].e_abc));
      chk($sformatf("vec%0d.def", i), 32'(def), 32'(vt[i].e_def));
      chk($sformatf("vec%0d.round_cnt", i), 32'(round_cnt), 32'(vt[i].e_rc));
    end

    // Simultaneous requests: both acks together, show on the very next edge.
    step(1'b1, 3'b000, 1'b1, 3'b101, 1'b1, "simul");
    chk("simul.both_ack", 32'(a_ack & b_ack), 32'd1);
    step(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, "simul");
    chk("simul.show", 32'(show), 32'd1);
    chk("simul.pair", 32'({abc, def}), 32'(6'b000101));
    idle(6, "simul");

    // Only A requests: timeout after exactly TOUT edges, then A with a blank partner.
    step(1'b1, 3'b101, 1'b0, 3'd0, 1'b1, "tout");
    n = 0;
    while (timeout_flag !== 1'b1 && n < 30) begin
      step(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, "tout");
      n++;
    end
    chk("tout.latency", n, TOUT);
    step(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, "tout");
    chk("tout.show", 32'(show), 32'd1);
    chk("tout.pair", 32'({abc, def}), 32'(6'b101011));
    chk("tout.flag_kept", 32'(timeout_flag), 32'd1);
    idle(6, "tout");

    // B keeps requesting through SHOW and GAP; accepted on the first COLLECT edge.
    step(1'b1, 3'b001, 1'b1, 3'b110, 1'b1, "bhold");
    n = 0;
    do begin
      step(1'b0, 3'd0, 1'b1, 3'b100, 1'b1, "bhold");
      n++;
    end while (b_ack !== 1'b1 && n < 20);
    chk("bhold.ack_step", n, 8);
    chk("bhold.tflag_cleared", 32'(timeout_flag), 32'd0);
    step(1'b1, 3'b010, 1'b0, 3'd0, 1'b1, "bhold");
    idle(2, "bhold");
    chk("bhold.in_show", 32'(show), 32'd1);

    // Asynchronous reset in the middle of SHOW, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("areset.show", 32'(show), 32'd0);
    chk("areset.busy", 32'(busy), 32'd0);
    chk("areset.abc", 32'(abc), BLANK);
    chk("areset.def", 32'(def), BLANK);
    chk("areset.round_cnt", 32'(round_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 256 back-to-back rounds wrap the round counter.
    for (int r = 0; r < 256; r++) begin
      step(1'b1, 3'(r), 1'b1, 3'(r + 3), 1'b1, "wrap");
      idle(7, "wrap");
      if (r == 254) chk("wrap.255", 32'(round_cnt), 32'd255);
    end
    chk("wrap.zero", 32'(round_cnt), 32'd0);

    // Random requesters that hold req and code until acknowledged.
    a_pend = 1'b0; b_pend = 1'b0; a_c = 3'd0; b_c = 3'd0;
    for (int i = 0; i < 800; i++) begin
      if (!a_pend && ($urandom_range(0, 11) == 0)) begin a_pend = 1'b1; a_c = 3'($urandom); end
      if (!b_pend && ($urandom_range(0, 11) == 0)) begin b_pend = 1'b1; b_c = 3'($urandom); end
      step(a_pend, a_c, b_pend, b_c, 1'b1, "rand");
      if (a_ack) a_pend = 1'b0;
      if (b_ack) b_pend = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
